// File: rtl/m_decode_issue.sv
// m_decode_issue: decode/issue stage with a one-deep hold register, a
// 32-entry register scoreboard, RAW hazard stalls and a valid/ready output.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready         fetch handshake, in_instruction payload
//   dec_instruction           held instruction driven to m_decoder
//   dec_rs_sel/dec_rq_sel     decoder source selects with *_used qualifiers
//   dec_rd/dec_rd_we          decoder destination and write enable
//   dec_decoded               decoder output bundle
//   out_valid/out_ready       execute handshake; out_decoded/out_rd/out_rd_we
//   wb_valid/wb_rd            writeback retiring a register write
//   flush                     discard held and unissued instructions
//   busy_mask                 scoreboard contents
//   stall_count               saturating count of hazard-stall cycles
//
// Optional: define M_DECODE_ISSUE_WB_BYPASS_EN so that a same-cycle
// writeback unblocks a waiting instruction without the extra cycle.

module m_decode_issue #(
    parameter int DECODED_W   = 128,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_instruction,
    output logic [31:0]            dec_instruction,
    input  logic [4:0]             dec_rs_sel,
    input  logic [4:0]             dec_rq_sel,
    input  logic                   dec_rs_used,
    input  logic                   dec_rq_used,
    input  logic [4:0]             dec_rd,
    input  logic                   dec_rd_we,
    input  logic [DECODED_W-1:0]   dec_decoded,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DECODED_W-1:0]   out_decoded,
    output logic [4:0]             out_rd,
    output logic                   out_rd_we,
    input  logic                   wb_valid,
    input  logic [4:0]             wb_rd,
    input  logic                   flush,
    output logic [31:0]            busy_mask,
    output logic [STALL_CNT_W-1:0] stall_count
);

    logic                   hold_valid_q, hold_valid_d;
    logic [31:0]            instr_q, instr_d;
    logic                   out_valid_q, out_valid_d;
    logic [DECODED_W-1:0]   out_decoded_q, out_decoded_d;
    logic [4:0]             out_rd_q, out_rd_d;
    logic                   out_rd_we_q, out_rd_we_d;
    logic [31:0]            busy_q, busy_d;
    logic [STALL_CNT_W-1:0] stall_q, stall_d;

    logic [31:0] busy_view;
    logic        hazard;
    logic        issue;
    logic        accept;

    always_comb begin
        busy_view    = busy_q;
        busy_view[0] = 1'b0;
`ifdef M_DECODE_ISSUE_WB_BYPASS_EN
        // A retiring write is already visible to the waiting reader.
        if (wb_valid) begin
            busy_view[wb_rd] = 1'b0;
        end
`endif
        hazard = hold_valid_q &&
                 ((dec_rs_used && busy_view[dec_rs_sel]) ||
                  (dec_rq_used && busy_view[dec_rq_sel]));
        issue    = hold_valid_q && !hazard && !flush &&
                   (!out_valid_q || out_ready);
        in_ready = !flush && (!hold_valid_q || issue);
        accept   = in_valid && in_ready;
    end

    always_comb begin
        hold_valid_d  = hold_valid_q;
        instr_d       = instr_q;
        out_valid_d   = out_valid_q;
        out_decoded_d = out_decoded_q;
        out_rd_d      = out_rd_q;
        out_rd_we_d   = out_rd_we_q;
        busy_d        = busy_q;
        stall_d       = stall_q;

        if (flush) begin
            hold_valid_d = 1'b0;
        end else if (accept) begin
            hold_valid_d = 1'b1;
            instr_d      = in_instruction;
        end else if (issue) begin
            hold_valid_d = 1'b0;
        end

        // A bundle handed over on the flush edge counts as consumed.
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (issue) begin
            out_valid_d   = 1'b1;
            out_decoded_d = dec_decoded;
            out_rd_d      = dec_rd;
            out_rd_we_d   = dec_rd_we;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        // Clears first so a same-cycle set of the same register wins.
        if (wb_valid) begin
            busy_d[wb_rd] = 1'b0;
        end
        if (flush && out_valid_q && out_rd_we_q && !out_ready) begin
            busy_d[out_rd_q] = 1'b0;
        end
        if (issue && dec_rd_we && dec_rd != 5'd0) begin
            busy_d[dec_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;

        if (hold_valid_q && hazard && !flush && stall_q != '1) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid_q  <= 1'b0;
            instr_q       <= '0;
            out_valid_q   <= 1'b0;
            out_decoded_q <= '0;
            out_rd_q      <= '0;
            out_rd_we_q   <= 1'b0;
            busy_q        <= '0;
            stall_q       <= '0;
        end else begin
            hold_valid_q  <= hold_valid_d;
            instr_q       <= instr_d;
            out_valid_q   <= out_valid_d;
            out_decoded_q <= out_decoded_d;
            out_rd_q      <= out_rd_d;
            out_rd_we_q   <= out_rd_we_d;
            busy_q        <= busy_d;
            stall_q       <= stall_d;
        end
    end

    assign dec_instruction = instr_q;
    assign out_valid       = out_valid_q;
    assign out_decoded     = out_decoded_q;
    assign out_rd          = out_rd_q;
    assign out_rd_we       = out_rd_we_q;
    assign busy_mask       = busy_q;
    assign stall_count     = stall_q;

endmodule

// File: tb/tb_m_decode_issue.sv
// Bench for m_decode_issue: directed scenarios plus random traffic,
// checked against a transaction-level model of the stage.

module tb_m_decode_issue;

    localparam int DW = 64;
    localparam int SW = 16;

`ifdef M_DECODE_ISSUE_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_instruction;
    logic [31:0]   dec_instruction;
    logic [4:0]    dec_rs_sel;
    logic [4:0]    dec_rq_sel;
    logic          dec_rs_used;
    logic          dec_rq_used;
    logic [4:0]    dec_rd;
    logic          dec_rd_we;
    logic [DW-1:0] dec_decoded;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_decoded;
    logic [4:0]    out_rd;
    logic          out_rd_we;
    logic          wb_valid;
    logic [4:0]    wb_rd;
    logic          flush;
    logic [31:0]   busy_mask;
    logic [SW-1:0] stall_count;

    always #5 clk = ~clk;

    m_decode_issue #(
        .DECODED_W  (DW),
        .STALL_CNT_W(SW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_instruction (in_instruction),
        .dec_instruction(dec_instruction),
        .dec_rs_sel     (dec_rs_sel),
        .dec_rq_sel     (dec_rq_sel),
        .dec_rs_used    (dec_rs_used),
        .dec_rq_used    (dec_rq_used),
        .dec_rd         (dec_rd),
        .dec_rd_we      (dec_rd_we),
        .dec_decoded    (dec_decoded),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_decoded    (out_decoded),
        .out_rd         (out_rd),
        .out_rd_we      (out_rd_we),
        .wb_valid       (wb_valid),
        .wb_rd          (wb_rd),
        .flush          (flush),
        .busy_mask      (busy_mask),
        .stall_count    (stall_count)
    );

    // Toy decoder: fixed bit fields of the held instruction.
    function automatic logic [DW-1:0] dec_of(input logic [31:0] i);
        return {i ^ 32'hA5A5_5A5A, i};
    endfunction

    assign dec_rs_used = dec_instruction[0];
    assign dec_rq_used = dec_instruction[1];
    assign dec_rd_we   = dec_instruction[2];
    assign dec_rd      = dec_instruction[11:7];
    assign dec_rs_sel  = dec_instruction[19:15];
    assign dec_rq_sel  = dec_instruction[24:20];
    assign dec_decoded = dec_of(dec_instruction);

    function automatic logic [31:0] mk(input int rd, input bit we,
                                       input int rs, input bit su,
                                       input int rq, input bit qu);
        logic [4:0] a, b, c;
        a = 5'(rd);
        b = 5'(rs);
        c = 5'(rq);
        return {7'b0, c, b, 3'b0, a, 4'b0, we, qu, su};
    endfunction

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Transaction-level model of the stage.
    bit            m_hold;
    logic [31:0]   m_instr;
    bit            m_ov;
    logic [DW-1:0] m_odec;
    logic [4:0]    m_ord;
    bit            m_owe;
    bit            m_busy [32];
    int            m_stall;

    function automatic bit seen_busy(input logic [4:0] r, input bit wbv,
                                     input logic [4:0] wbr);
        if (r == 5'd0) return 1'b0;
        if (BYPASS && wbv && wbr == r) return 1'b0;
        return m_busy[r];
    endfunction

    function automatic logic [31:0] busy_pack();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = m_busy[i];
        return v;
    endfunction

    task automatic model_reset();
        m_hold  = 1'b0;
        m_instr = '0;
        m_ov    = 1'b0;
        m_odec  = '0;
        m_ord   = '0;
        m_owe   = 1'b0;
        m_stall = 0;
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    endtask

    // One clock: drive inputs after negedge, check in_ready, advance the
    // model at the posedge and compare all registered outputs.
    task automatic step(input bit r, input bit iv, input logic [31:0] ins,
                        input bit ordy, input bit wbv,
                        input logic [4:0] wbr, input bit fl);
        bit hz, iss, rdy, acc;
        rst            = r;
        in_valid       = iv;
        in_instruction = ins;
        out_ready      = ordy;
        wb_valid       = wbv;
        wb_rd          = wbr;
        flush          = fl;
        #1;
        hz  = m_hold &&
              ((m_instr[0] && seen_busy(m_instr[19:15], wbv, wbr)) ||
               (m_instr[1] && seen_busy(m_instr[24:20], wbv, wbr)));
        iss = m_hold && !hz && !fl && (!m_ov || ordy);
        rdy = !fl && (!m_hold || iss);
        acc = iv && rdy;
        chk("in_ready", 64'(in_ready), 64'(rdy));
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            if (wbv) m_busy[wbr] = 1'b0;
            if (fl && m_ov && m_owe && !ordy) m_busy[m_ord] = 1'b0;
            if (iss && m_instr[2] && m_instr[11:7] != 5'd0)
                m_busy[m_instr[11:7]] = 1'b1;
            m_busy[0] = 1'b0;
            if (m_hold && hz && !fl && m_stall < 65535) m_stall++;
            if (fl) begin
                m_ov = 1'b0;
            end else if (iss) begin
                m_ov   = 1'b1;
                m_odec = dec_of(m_instr);
                m_ord  = m_instr[11:7];
                m_owe  = m_instr[2];
            end else if (ordy) begin
                m_ov = 1'b0;
            end
            if (fl) begin
                m_hold = 1'b0;
            end else if (acc) begin
                m_hold  = 1'b1;
                m_instr = ins;
            end else if (iss) begin
                m_hold = 1'b0;
            end
        end
        #1;
        chk("out_valid", 64'(out_valid), 64'(m_ov));
        chk("out_decoded", out_decoded, m_odec);
        chk("out_rd", 64'(out_rd), 64'(m_ord));
        chk("out_rd_we", 64'(out_rd_we), 64'(m_owe));
        chk("dec_instruction", 64'(dec_instruction), 64'(m_instr));
        chk("busy_mask", 64'(busy_mask), 64'(busy_pack()));
        chk("stall_count", 64'(stall_count), 64'(m_stall));
        @(negedge clk);
    endtask

    task automatic idle(input bit ordy);
        step(1'b0, 1'b0, 32'h0, ordy, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic push(input logic [31:0] ins, input bit ordy);
        step(1'b0, 1'b1, ins, ordy, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 5'd0, 1'b0);
    endtask

    initial begin
        logic [31:0] ia, ib, ic;
        model_reset();
        @(negedge clk);

        // Reset from unknown state, then rd=3 flows through.
        do_reset();
        do_reset();
        chk("rst_busy", 64'(busy_mask), 64'h0);
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        ia = mk(3, 1, 0, 0, 0, 0);
        push(ia, 1'b1);
        chk("t1_hold_no_out", 64'(out_valid), 64'h0);
        idle(1'b1);
        chk("t1_out_valid", 64'(out_valid), 64'h1);
        chk("t1_out_rd", 64'(out_rd), 64'h3);
        chk("t1_busy", 64'(busy_mask), 64'h8);

        // RAW stall on r5, released by writeback.
        do_reset();
        ia = mk(5, 1, 0, 0, 0, 0);
        ib = mk(6, 1, 5, 1, 0, 0);
        push(ia, 1'b1);
        push(ib, 1'b1);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);
        chk("raw_stall3", 64'(stall_count), 64'h3);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 5'd5, 1'b0);
        chk("raw_wb_cycle", 64'(out_valid), 64'(BYPASS));
        idle(1'b1);
        chk("raw_after_wb", 64'(out_valid), 64'(!BYPASS));

        // Back-pressure: BOTH state, then one issue per cycle.
        do_reset();
        ia = mk(1, 1, 0, 0, 0, 0);
        ib = mk(2, 1, 0, 0, 0, 0);
        ic = mk(4, 1, 0, 0, 0, 0);
        push(ia, 1'b0);
        push(ib, 1'b0);
        push(ic, 1'b0);
        push(ic, 1'b0);
        push(ic, 1'b0);
        chk("bp_stable", out_decoded, dec_of(ia));
        push(ic, 1'b1);
        chk("bp_issue_b", out_decoded, dec_of(ib));
        idle(1'b1);
        chk("bp_issue_c", out_decoded, dec_of(ic));

        // r0 never marks busy and never stalls.
        do_reset();
        ia = mk(0, 1, 0, 0, 0, 0);
        ib = mk(0, 0, 0, 1, 0, 1);
        push(ia, 1'b1);
        push(ib, 1'b1);
        idle(1'b1);
        chk("r0_busy", 64'(busy_mask), 64'h0);
        chk("r0_stall", 64'(stall_count), 64'h0);
        chk("r0_out", out_decoded, dec_of(ib));

        // Flush with the issued rd=7 still unconsumed.
        do_reset();
        ia = mk(7, 1, 0, 0, 0, 0);
        ib = mk(8, 1, 7, 1, 0, 0);
        push(ia, 1'b0);
        push(ib, 1'b0);
        step(1'b0, 1'b1, ib, 1'b0, 1'b0, 5'd0, 1'b1);
        chk("fl_busy_cleared", 64'(busy_mask), 64'h0);
        chk("fl_out_valid", 64'(out_valid), 64'h0);

        // Flush on the edge where execute takes rd=7.
        do_reset();
        push(ia, 1'b0);
        push(ib, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 1'b1);
        chk("fl_busy_kept", 64'(busy_mask), 64'h80);
        chk("fl2_out_valid", 64'(out_valid), 64'h0);

        // Writeback and issue of r9 in the same cycle.
        do_reset();
        ia = mk(9, 1, 0, 0, 0, 0);
        push(ia, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 5'd9, 1'b0);
        chk("wb_set_wins", 64'(busy_mask), 64'h200);

        // Random traffic.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] ri;
            bit          rv, ro, rw, rf;
            logic [4:0]  rr;
            ri = mk($urandom_range(0, 7), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 7), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 7), 1'($urandom_range(0, 1)));
            rv = ($urandom_range(0, 9) < 7);
            ro = ($urandom_range(0, 9) < 7);
            rw = ($urandom_range(0, 9) < 4);
            rr = 5'($urandom_range(0, 7));
            rf = ($urandom_range(0, 99) < 3);
            step(1'b0, rv, ri, ro, rw, rr, rf);
        end

        // Stall counter saturation.
        do_reset();
        ia = mk(5, 1, 0, 0, 0, 0);
        ib = mk(6, 1, 5, 1, 0, 0);
        push(ia, 1'b1);
        push(ib, 1'b1);
        for (int n = 0; n < 65541; n++) idle(1'b1);
        chk("stall_sat", 64'(stall_count), 64'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
